// File: rtl/branch_predict_ctrl_pkg.sv
// Shared definitions for the branch predictor: FSM encodings, 2-bit counter
// encodings, the branch func3 constants and the counter update helper.
package branch_predict_ctrl_pkg;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_FLUSH = 1'b1;

    localparam logic [1:0] CNT_SNT = 2'b00;
    localparam logic [1:0] CNT_WNT = 2'b01;
    localparam logic [1:0] CNT_WT  = 2'b10;
    localparam logic [1:0] CNT_ST  = 2'b11;

    localparam logic [2:0] BR_BEQ  = 3'b000;
    localparam logic [2:0] BR_BNE  = 3'b001;
    localparam logic [2:0] BR_BLT  = 3'b100;
    localparam logic [2:0] BR_BGE  = 3'b101;
    localparam logic [2:0] BR_BLTU = 3'b110;
    localparam logic [2:0] BR_BGEU = 3'b111;

    // Saturating step of a 2-bit bimodal counter toward the resolved outcome.
    function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic taken);
        if (taken)
            return (ctr == CNT_ST) ? CNT_ST : ctr + 2'd1;
        else
            return (ctr == CNT_SNT) ? CNT_SNT : ctr - 2'd1;
    endfunction

endpackage

// File: rtl/branch_predict_ctrl_btb_array.sv
// BTB/BHT entry storage: two combinational read ports (fetch lookup and
// EX-stage update read) and one synchronous write port.
module btb_array
    import branch_predict_ctrl_pkg::*;
#(
    parameter int ENTRIES = 16,
    parameter int TAG_W   = 26,
    parameter int PC_W    = 32,
    parameter int IDX_W   = $clog2(ENTRIES)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IDX_W-1:0] rd0_idx,
    output logic             rd0_valid,
    output logic [TAG_W-1:0] rd0_tag,
    output logic [PC_W-1:0]  rd0_target,
    output logic [1:0]       rd0_ctr,
    input  logic [IDX_W-1:0] rd1_idx,
    output logic             rd1_valid,
    output logic [TAG_W-1:0] rd1_tag,
    output logic [PC_W-1:0]  rd1_target,
    output logic [1:0]       rd1_ctr,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [TAG_W-1:0] wr_tag,
    input  logic [PC_W-1:0]  wr_target,
    input  logic [1:0]       wr_ctr
);

    logic             valid_q  [ENTRIES];
    logic [1:0]       ctr_q    [ENTRIES];
    logic [TAG_W-1:0] tag_q    [ENTRIES];
    logic [PC_W-1:0]  target_q [ENTRIES];

    // NOTE: only valid and counter bits are reset; tag/target are qualified by
    // valid, so leaving them unreset lets them map onto plain storage.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
                ctr_q[i]   <= CNT_WNT;
            end
        end else if (wr_en) begin
            valid_q[wr_idx] <= 1'b1;
            ctr_q[wr_idx]   <= wr_ctr;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_q[wr_idx]    <= wr_tag;
            target_q[wr_idx] <= wr_target;
        end
    end

    // Reads see pre-write contents when a write to the same index is pending.
    assign rd0_valid  = valid_q[rd0_idx];
    assign rd0_tag    = tag_q[rd0_idx];
    assign rd0_target = target_q[rd0_idx];
    assign rd0_ctr    = ctr_q[rd0_idx];
    assign rd1_valid  = valid_q[rd1_idx];
    assign rd1_tag    = tag_q[rd1_idx];
    assign rd1_target = target_q[rd1_idx];
    assign rd1_ctr    = ctr_q[rd1_idx];

endmodule

// File: rtl/branch_predict_ctrl.sv
// Bimodal branch predictor with BTB: zero-latency fetch prediction, EX-stage
// resolution, one-cycle flush/redirect and a saturating mispredict counter.
module branch_predict_ctrl
    import branch_predict_ctrl_pkg::*;
#(
    parameter int ENTRIES = 16,
    parameter int PC_W    = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall,
    input  logic            if_valid,
    input  logic [PC_W-1:0] if_pc,
    output logic            pred_taken,
    output logic [PC_W-1:0] pred_target,
    input  logic            ex_is_branch,
    input  logic [PC_W-1:0] ex_pc,
    input  logic            ex_taken,
    input  logic [PC_W-1:0] ex_target,
    output logic            flush,
    output logic            redirect_valid,
    output logic [PC_W-1:0] redirect_pc,
    output logic [15:0]     mispredict_cnt
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = PC_W - IDX_W - 2;

    logic [IDX_W-1:0] if_idx, ex_idx;
    logic [TAG_W-1:0] if_tag, ex_tag;
    logic             rd0_valid, rd1_valid;
    logic [TAG_W-1:0] rd0_tag, rd1_tag;
    logic [PC_W-1:0]  rd0_target, rd1_target;
    logic [1:0]       rd0_ctr, rd1_ctr;
    logic             wr_en;
    logic [PC_W-1:0]  wr_target;
    logic [1:0]       wr_ctr;

    logic [0:0]       state;
    logic             id_pred, ex_pred;
    logic [PC_W-1:0]  id_tgt, ex_tgt;
    logic             mispredict, go_flush, upd_en, ex_hit;
    logic             unused_pc_bits;

    assign if_idx = if_pc[IDX_W+1:2];
    assign if_tag = if_pc[PC_W-1:IDX_W+2];
    assign ex_idx = ex_pc[IDX_W+1:2];
    assign ex_tag = ex_pc[PC_W-1:IDX_W+2];
    assign unused_pc_bits = ^{if_pc[1:0], ex_pc[1:0]};

    btb_array #(.ENTRIES(ENTRIES), .TAG_W(TAG_W), .PC_W(PC_W)) u_btb (
        .clk        (clk),
        .rst_n      (rst_n),
        .rd0_idx    (if_idx),
        .rd0_valid  (rd0_valid),
        .rd0_tag    (rd0_tag),
        .rd0_target (rd0_target),
        .rd0_ctr    (rd0_ctr),
        .rd1_idx    (ex_idx),
        .rd1_valid  (rd1_valid),
        .rd1_tag    (rd1_tag),
        .rd1_target (rd1_target),
        .rd1_ctr    (rd1_ctr),
        .wr_en      (wr_en),
        .wr_idx     (ex_idx),
        .wr_tag     (ex_tag),
        .wr_target  (wr_target),
        .wr_ctr     (wr_ctr)
    );

    assign pred_taken  = rd0_valid && (rd0_tag == if_tag) && rd0_ctr[1];
    assign pred_target = pred_taken ? rd0_target : '0;

    assign mispredict = ex_is_branch &&
                        ((ex_taken != ex_pred) ||
                         (ex_taken && ex_pred && (ex_target != ex_tgt)));
    // The FLUSH cycle is a bubble in EX, so nothing there updates or redirects.
    assign go_flush = (state == ST_IDLE) && mispredict && !stall;
    assign upd_en   = (state == ST_IDLE) && ex_is_branch && !stall;
    assign ex_hit   = rd1_valid && (rd1_tag == ex_tag);

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        wr_en     = 1'b0;
        wr_target = ex_target;
        wr_ctr    = CNT_WT;
        if (upd_en) begin
            if (ex_hit) begin
                wr_en     = 1'b1;
                wr_ctr    = ctr_next(rd1_ctr, ex_taken);
                wr_target = ex_taken ? ex_target : rd1_target;
            end else if (ex_taken) begin
                wr_en = 1'b1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= ST_IDLE;
            flush          <= 1'b0;
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
            mispredict_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (go_flush) begin
                        state          <= ST_FLUSH;
                        flush          <= 1'b1;
                        redirect_valid <= 1'b1;
                        redirect_pc    <= ex_taken ? ex_target : ex_pc + PC_W'(4);
                        if (mispredict_cnt != 16'hFFFF)
                            mispredict_cnt <= mispredict_cnt + 16'd1;
                    end
                end
                default: begin
                    state          <= ST_IDLE;
                    flush          <= 1'b0;
                    redirect_valid <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || state == ST_FLUSH) begin
            id_pred <= 1'b0;
            id_tgt  <= '0;
            ex_pred <= 1'b0;
            ex_tgt  <= '0;
        end else if (!stall) begin
            id_pred <= if_valid && pred_taken;
            id_tgt  <= if_valid ? pred_target : '0;
            ex_pred <= id_pred;
            ex_tgt  <= id_tgt;
        end
    end

endmodule

// File: tb/tb_branch_predict_ctrl.sv
// Directed bench for branch_predict_ctrl: trains one BTB entry through cold
// miss, saturation, bubble, stall and reset-in-flush scenarios.
module tb_branch_predict_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic        if_valid;
    logic [31:0] if_pc;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        ex_is_branch;
    logic [31:0] ex_pc;
    logic        ex_taken;
    logic [31:0] ex_target;
    logic        flush;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [15:0] mispredict_cnt;

    int n_checks = 0;
    int n_errors = 0;

    branch_predict_ctrl #(.ENTRIES(16), .PC_W(32)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .stall          (stall),
        .if_valid       (if_valid),
        .if_pc          (if_pc),
        .pred_taken     (pred_taken),
        .pred_target    (pred_target),
        .ex_is_branch   (ex_is_branch),
        .ex_pc          (ex_pc),
        .ex_taken       (ex_taken),
        .ex_target      (ex_target),
        .flush          (flush),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .mispredict_cnt (mispredict_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic lookup(input string tag, input logic [31:0] pc,
                          input logic exp_taken, input logic [31:0] exp_tgt);
        if_pc = pc;
        #1;
        check({tag, "_taken"}, {31'd0, pred_taken}, {31'd0, exp_taken});
        check({tag, "_target"}, pred_target, exp_tgt);
    endtask

    // Fetch pc, let it reach EX, then resolve it; returns one cycle after the
    // resolving edge, i.e. inside the FLUSH cycle when a mispredict occurred.
    task automatic do_branch(input logic [31:0] pc, input logic taken, input logic [31:0] tgt);
        if_valid = 1'b1;
        if_pc    = pc;
        step();
        if_valid = 1'b0;
        step();
        ex_is_branch = 1'b1;
        ex_pc        = pc;
        ex_taken     = taken;
        ex_target    = tgt;
        step();
        ex_is_branch = 1'b0;
    endtask

    task automatic expect_flush(input string tag, input logic [31:0] rpc, input logic [15:0] cnt);
        check({tag, "_flush"}, {31'd0, flush}, 32'd1);
        check({tag, "_rvalid"}, {31'd0, redirect_valid}, 32'd1);
        check({tag, "_rpc"}, redirect_pc, rpc);
        check({tag, "_cnt"}, {16'd0, mispredict_cnt}, {16'd0, cnt});
        step();
        check({tag, "_flush_end"}, {31'd0, flush}, 32'd0);
    endtask

    task automatic expect_no_flush(input string tag, input logic [15:0] cnt);
        check({tag, "_noflush"}, {31'd0, flush}, 32'd0);
        check({tag, "_cnt"}, {16'd0, mispredict_cnt}, {16'd0, cnt});
    endtask

    initial begin
        rst_n = 1'b0; stall = 1'b0; if_valid = 1'b0; if_pc = '0;
        ex_is_branch = 1'b0; ex_pc = '0; ex_taken = 1'b0; ex_target = '0;
        step();
        step();
        rst_n = 1'b1;

        check("rst_flush", {31'd0, flush}, 32'd0);
        check("rst_rvalid", {31'd0, redirect_valid}, 32'd0);
        check("rst_rpc", redirect_pc, 32'd0);
        check("rst_cnt", {16'd0, mispredict_cnt}, 32'd0);
        lookup("cold", 32'h100, 1'b0, 32'h0);

        // Cold taken branch allocates with counter WT.
        do_branch(32'h100, 1'b1, 32'h200);
        expect_flush("alloc", 32'h200, 16'd1);
        lookup("after_alloc", 32'h100, 1'b1, 32'h200);

        // Three correct taken predictions drive the counter to ST and stop there.
        for (int i = 0; i < 3; i++) begin
            do_branch(32'h100, 1'b1, 32'h200);
            expect_no_flush("train_t", 16'd1);
        end
        do_branch(32'h100, 1'b0, 32'h104);
        expect_flush("nt1", 32'h104, 16'd2);
        lookup("after_nt1", 32'h100, 1'b1, 32'h200);
        do_branch(32'h100, 1'b0, 32'h104);
        expect_flush("nt2", 32'h104, 16'd3);
        lookup("after_nt2", 32'h100, 1'b0, 32'h0);

        // WNT -> WT, then a predicted-taken branch resolves not-taken.
        do_branch(32'h100, 1'b1, 32'h200);
        expect_flush("retrain", 32'h200, 16'd4);
        lookup("alias", 32'h140, 1'b0, 32'h0);
        lookup("retrained", 32'h100, 1'b1, 32'h200);
        do_branch(32'h100, 1'b0, 32'h104);
        check("bubble_flush", {31'd0, flush}, 32'd1);
        check("bubble_rpc", redirect_pc, 32'h104);
        ex_is_branch = 1'b1; ex_pc = 32'h100; ex_taken = 1'b1; ex_target = 32'h300;
        step();
        ex_is_branch = 1'b0;
        expect_no_flush("bubble", 16'd5);
        lookup("bubble_noupd", 32'h100, 1'b0, 32'h0);

        // Stall holds the EX branch: no update, no flush until it drops.
        if_valid = 1'b1; if_pc = 32'h100; step();
        if_valid = 1'b0; step();
        stall = 1'b1;
        ex_is_branch = 1'b1; ex_pc = 32'h100; ex_taken = 1'b1; ex_target = 32'h200;
        for (int i = 0; i < 3; i++) begin
            step();
            expect_no_flush("stall", 16'd5);
            lookup("stall_noupd", 32'h100, 1'b0, 32'h0);
        end
        stall = 1'b0;
        step();
        ex_is_branch = 1'b0;
        expect_flush("unstall", 32'h200, 16'd6);
        lookup("unstall_upd", 32'h100, 1'b1, 32'h200);
        // A single update leaves WT, so one not-taken drops below threshold.
        do_branch(32'h100, 1'b0, 32'h104);
        expect_flush("once", 32'h104, 16'd7);
        lookup("once_upd", 32'h100, 1'b0, 32'h0);

        // Taken with a different target than predicted is a mispredict.
        do_branch(32'h100, 1'b1, 32'h200);
        expect_flush("retrain2", 32'h200, 16'd8);
        do_branch(32'h100, 1'b1, 32'h280);
        expect_flush("tgt_miss", 32'h280, 16'd9);
        lookup("new_tgt", 32'h100, 1'b1, 32'h280);

        // Reset in the FLUSH cycle aborts the redirect and clears the table.
        do_branch(32'h100, 1'b0, 32'h104);
        check("pre_rst_flush", {31'd0, flush}, 32'd1);
        check("pre_rst_cnt", {16'd0, mispredict_cnt}, 32'd10);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check("rst_in_flush_flush", {31'd0, flush}, 32'd0);
        check("rst_in_flush_rvalid", {31'd0, redirect_valid}, 32'd0);
        check("rst_in_flush_cnt", {16'd0, mispredict_cnt}, 32'd0);
        lookup("rst_in_flush_miss", 32'h100, 1'b0, 32'h0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
